float_alu_arbiter: RTL and testbench

- Round-robin arbiter that shares one float_alu instance between N_REQ requesters.
- Each requester has a valid/ready request channel carrying operands, op_code, round_mode and mode_fp.
- Each requester has a valid/ready response channel carrying result and flags.
- One operation in flight at a time. Sits between the issue ports of the core pipelines and the shared float_alu.

---
 rtl/float_alu_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 28 ++
 rtl/float_alu_arbiter.sv | 164 ++++++++++++++++
 tb/tb_float_alu_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/float_alu_pkg.sv
// float_alu_pkg: op codes, flag bit indices, canonical NaN and arbiter state encoding
// shared by the float_alu arbiter and its users.
package float_alu_pkg;
    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_MUL  = 3'd2;
    localparam logic [2:0] OP_DIV  = 3'd3;
    localparam logic [2:0] OP_SQRT = 3'd4;
    localparam logic [2:0] OP_CMP  = 3'd5;
    localparam logic [2:0] OP_MIN  = 3'd6;
    localparam logic [2:0] OP_MAX  = 3'd7;

    localparam int FLAG_INVALID = 4;
    localparam int FLAG_DIVZ    = 3;
    localparam int FLAG_OVF     = 2;
    localparam int FLAG_UNF     = 1;
    localparam int FLAG_INEXACT = 0;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request after last_grant,
// returned both one-hot and encoded.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last_grant,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] idx
);
    localparam int W = $clog2(N);

    int j;

    // Scan farthest-first so the nearest requester after last_grant overwrites last.
    always_comb begin
        grant = '0;
        idx = '0;
        j = 0;
        for (int k = N; k >= 1; k--) begin
            j = (int'(last_grant) + k) % N;
            if (req[j]) begin
                grant = N'(1) << j;
                idx = W'(j);
            end
        end
    end
endmodule

// File: rtl/float_alu_arbiter.sv
// float_alu_arbiter: round-robin sharing of one float_alu among N_REQ requesters, one op in flight.
// Optional per-requester sticky flag accumulation under FLOAT_ARB_STICKY_FLAGS_EN.
module float_alu_arbiter
    import float_alu_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [32*N_REQ-1:0]  req_op_a,
    input  logic [32*N_REQ-1:0]  req_op_b,
    input  logic [3*N_REQ-1:0]   req_op_code,
    input  logic [N_REQ-1:0]     req_round_mode,
    input  logic [N_REQ-1:0]     req_mode_fp,
    output logic [N_REQ-1:0]     rsp_valid,
    input  logic [N_REQ-1:0]     rsp_ready,
    output logic [31:0]          rsp_result,
    output logic [4:0]           rsp_flags,
    output logic [31:0]          alu_op_a,
    output logic [31:0]          alu_op_b,
    output logic [2:0]           alu_op_code,
    output logic                 alu_round_mode,
    output logic                 alu_mode_fp,
    output logic                 alu_start,
    output logic                 alu_ready_in,
    input  logic                 alu_ready_out,
    input  logic                 alu_valid_out,
    input  logic [31:0]          alu_result,
`ifdef FLOAT_ARB_STICKY_FLAGS_EN
    output logic [5*N_REQ-1:0]   sticky_flags,
    input  logic [N_REQ-1:0]     sticky_clr,
`endif
    input  logic [4:0]           alu_flags
);
    localparam int GW = $clog2(N_REQ);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    state_e          state_q, state_d;
    logic [GW-1:0]   g_q, g_d, last_q, last_d, arb_idx;
    logic [N_REQ-1:0] arb_grant;
    logic [31:0]     a_q, a_d, b_q, b_d, res_q, res_d;
    logic [2:0]      code_q, code_d;
    logic            rm_q, rm_d, fp_q, fp_d;
    logic [4:0]      flags_q, flags_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            go, drive, rsp_take, expired;

    rr_arbiter #(.N(N_REQ)) u_rr (
        .req        (req_valid),
        .last_grant (last_q),
        .grant      (arb_grant),
        .idx        (arb_idx)
    );

    // rst_n gates the grant so no req_ready can leak while the block is held in reset.
    assign go       = rst_n && alu_ready_out && (state_q == IDLE) && (|req_valid);
    assign drive    = (state_q == ISSUE) || (state_q == WAIT);
    assign rsp_take = (state_q == RESP) && rsp_ready[g_q];
    assign expired  = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));

    assign req_ready      = go ? arb_grant : '0;
    assign rsp_valid      = (state_q == RESP) ? N_REQ'(1) << g_q : '0;
    assign rsp_result     = res_q;
    assign rsp_flags      = flags_q;
    assign alu_op_a       = drive ? a_q : '0;
    assign alu_op_b       = drive ? b_q : '0;
    assign alu_op_code    = drive ? code_q : '0;
    assign alu_round_mode = drive && rm_q;
    assign alu_mode_fp    = drive && fp_q;
    assign alu_start      = (state_q == ISSUE);
    assign alu_ready_in   = (state_q == WAIT);

    always_comb begin
        state_d = state_q;
        g_d = g_q;
        last_d = last_q;
        a_d = a_q;
        b_d = b_q;
        code_d = code_q;
        rm_d = rm_q;
        fp_d = fp_q;
        res_d = res_q;
        flags_d = flags_q;
        cnt_d = '0;
        case (state_q)
            IDLE: if (go) begin
                state_d = ISSUE;
                g_d = arb_idx;
                a_d = req_op_a[32*arb_idx +: 32];
                b_d = req_op_b[32*arb_idx +: 32];
                code_d = req_op_code[3*arb_idx +: 3];
                rm_d = req_round_mode[arb_idx];
                fp_d = req_mode_fp[arb_idx];
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (alu_valid_out) begin
                    state_d = RESP;
                    res_d = alu_result;
                    flags_d = alu_flags;
                end else if (expired) begin
                    state_d = RESP;
                    res_d = QNAN;
                    flags_d = 5'(1 << FLAG_INVALID);
                end
            end
            default: if (rsp_take) begin
                state_d = IDLE;
                last_d = g_q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            g_q <= '0;
            last_q <= GW'(N_REQ - 1);
            a_q <= '0;
            b_q <= '0;
            code_q <= '0;
            rm_q <= 1'b0;
            fp_q <= 1'b0;
            res_q <= '0;
            flags_q <= '0;
            cnt_q <= '0;
        end else begin
            state_q <= state_d;
            g_q <= g_d;
            last_q <= last_d;
            a_q <= a_d;
            b_q <= b_d;
            code_q <= code_d;
            rm_q <= rm_d;
            fp_q <= fp_d;
            res_q <= res_d;
            flags_q <= flags_d;
            cnt_q <= cnt_d;
        end
    end

`ifdef FLOAT_ARB_STICKY_FLAGS_EN
    logic [5*N_REQ-1:0] sticky_q, sticky_d;

    // A clear beats an update landing in the same cycle.
    always_comb begin
        sticky_d = sticky_q;
        for (int i = 0; i < N_REQ; i++)
            sticky_d[5*i +: 5] = sticky_clr[i] ? 5'b0 :
                sticky_q[5*i +: 5] | ((rsp_take && g_q == GW'(i)) ? flags_q : 5'b0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sticky_q <= '0;
        else sticky_q <= sticky_d;
    end

    assign sticky_flags = sticky_q;
`endif
endmodule

// File: tb/tb_float_alu_arbiter.sv
// tb_float_alu_arbiter: directed checks of grant order, result routing, back-pressure,
// watchdog and mid-operation reset against a small fixed-latency ALU stub.
module tb_float_alu_arbiter;
    import float_alu_pkg::*;

    localparam int N = 2;
    localparam int LAT = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [N-1:0] req_valid = '0, req_round_mode = '0, req_mode_fp = '0, rsp_ready = '0;
    logic [N-1:0] req_ready, rsp_valid;
    logic [32*N-1:0] req_op_a = '0, req_op_b = '0;
    logic [3*N-1:0] req_op_code = '0;
    logic [31:0] rsp_result, alu_op_a, alu_op_b, alu_result;
    logic [4:0] rsp_flags, alu_flags;
    logic [2:0] alu_op_code;
    logic alu_round_mode, alu_mode_fp, alu_start, alu_ready_in, alu_ready_out, alu_valid_out;

    logic hang = 1'b0;
    logic busy, mv;
    int cnt;
    logic [31:0] mres;
    logic [4:0] mflg;

    int errors = 0, checks = 0;
    int g1 = 0, starts = 0, waits = 0, v1 = 0;
    int s_starts, s_g1, s_w, s_v1, bad;

    always #5 clk = ~clk;

    float_alu_arbiter #(.N_REQ(N), .TIMEOUT(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_op_a       (req_op_a),
        .req_op_b       (req_op_b),
        .req_op_code    (req_op_code),
        .req_round_mode (req_round_mode),
        .req_mode_fp    (req_mode_fp),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_result     (rsp_result),
        .rsp_flags      (rsp_flags),
        .alu_op_a       (alu_op_a),
        .alu_op_b       (alu_op_b),
        .alu_op_code    (alu_op_code),
        .alu_round_mode (alu_round_mode),
        .alu_mode_fp    (alu_mode_fp),
        .alu_start      (alu_start),
        .alu_ready_in   (alu_ready_in),
        .alu_ready_out  (alu_ready_out),
        .alu_valid_out  (alu_valid_out),
        .alu_result     (alu_result),
        .alu_flags      (alu_flags)
    );

    // ALU stub: answers the known vectors with hand-computed results.
    function automatic logic [36:0] alu_fn(input logic [31:0] a, input logic [31:0] b, input logic rm);
        if (a == 32'h41A6_0000 && b == 32'h4010_0000) return {5'b00000, 32'h41B8_0000};
        if (a == 32'h4160_0000 && b == 32'hC144_0000) return {5'b00000, 32'h3FE0_0000};
        if (a == 32'h3DCC_CCCD && b == 32'h3E4C_CCCD) return {5'b00001, rm ? 32'h3E99_9999 : 32'h3E99_999A};
        return {5'b00000, 32'hDEAD_BEEF};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            mv <= 1'b0;
            cnt <= 0;
        end else begin
            mv <= 1'b0;
            if (alu_start) begin
                busy <= 1'b1;
                cnt <= LAT;
                {mflg, mres} <= alu_fn(alu_op_a, alu_op_b, alu_round_mode);
            end else if (busy && !hang) begin
                cnt <= cnt - 1;
                if (cnt == 1) begin
                    busy <= 1'b0;
                    mv <= 1'b1;
                end
            end
        end
    end

    assign alu_ready_out = !busy;
    assign alu_valid_out = mv;
    assign alu_result = mv ? mres : 32'h0;
    assign alu_flags = mv ? mflg : 5'h0;

    always @(posedge clk) begin
        if (req_ready[1]) g1 <= g1 + 1;
        if (alu_start) starts <= starts + 1;
        if (alu_ready_in) waits <= waits + 1;
        if (rsp_valid[1]) v1 <= v1 + 1;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic rm);
        req_op_a[32*i +: 32] = a;
        req_op_b[32*i +: 32] = b;
        req_op_code[3*i +: 3] = OP_ADD;
        req_round_mode[i] = rm;
        req_mode_fp[i] = 1'b1;
    endtask

    task automatic wait_rsp(input int i);
        for (int k = 0; k < 40 && !rsp_valid[i]; k++) @(negedge clk);
        chk("rsp_valid_seen", 32'(rsp_valid[i]), 32'd1);
    endtask

    task automatic wait_grant();
        #1;
        for (int k = 0; k < 20 && req_ready == '0; k++) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic take(input int i);
        rsp_ready[i] = 1'b1;
        @(negedge clk);
        rsp_ready = '0;
    endtask

    initial begin
        @(negedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_alu_start", 32'(alu_start), 32'd0);
        chk("rst_alu_op_a", alu_op_a, 32'd0);
        chk("rst_rsp_result", rsp_result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        set_req(0, 32'h41A6_0000, 32'h4010_0000, 1'b0);
        req_valid = 2'b01;
        #1 chk("t1_grant", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = '0;
        #1;
        chk("t1_no_regrant", 32'(req_ready), 32'd0);
        chk("t1_alu_start", 32'(alu_start), 32'd1);
        chk("t1_alu_op_a", alu_op_a, 32'h41A6_0000);
        wait_rsp(0);
        chk("t1_result", rsp_result, 32'h41B8_0000);
        chk("t1_flags", 32'(rsp_flags), 32'd0);
        take(0);
        chk("t1_rsp_clear", 32'(rsp_valid), 32'd0);

        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        set_req(0, 32'h4160_0000, 32'hC144_0000, 1'b0);
        set_req(1, 32'h3DCC_CCCD, 32'h3E4C_CCCD, 1'b0);
        req_valid = 2'b11;
        wait_grant();
        chk("t2_first_grant", 32'(req_ready), 32'd1);
        wait_rsp(0);
        chk("t2_r0_only", 32'(rsp_valid), 32'd1);
        chk("t2_r0_result", rsp_result, 32'h3FE0_0000);
        take(0);
        wait_grant();
        chk("t2_second_grant", 32'(req_ready), 32'd2);
        wait_rsp(1);
        chk("t2_r1_result", rsp_result, 32'h3E99_999A);
        chk("t2_r1_flags", 32'(rsp_flags), 32'd1);
        take(1);
        wait_grant();
        chk("t2_alt_r0", 32'(req_ready), 32'd1);
        wait_rsp(0);
        take(0);
        wait_grant();
        chk("t2_alt_r1", 32'(req_ready), 32'd2);
        @(negedge clk);
        req_valid = '0;
        wait_rsp(1);
        take(1);

        set_req(1, 32'h3DCC_CCCD, 32'h3E4C_CCCD, 1'b1);
        req_valid = 2'b10;
        wait_grant();
        @(negedge clk);
        req_valid = '0;
        #1 chk("t3_alu_rm", 32'(alu_round_mode), 32'd1);
        wait_rsp(1);
        chk("t3_rtz_result", rsp_result, 32'h3E99_9999);
        chk("t3_rtz_flags", 32'(rsp_flags), 32'd1);
        take(1);

        set_req(0, 32'h41A6_0000, 32'h4010_0000, 1'b0);
        req_valid = 2'b01;
        wait_grant();
        @(negedge clk);
        req_valid = 2'b11;
        wait_rsp(0);
        s_starts = starts;
        s_g1 = g1;
        bad = 0;
        rsp_ready = 2'b10;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid !== 2'b01 || rsp_result !== 32'h41B8_0000) bad++;
        end
        chk("t4_stable", 32'(bad), 32'd0);
        chk("t4_no_start", 32'(starts - s_starts), 32'd0);
        chk("t4_no_r1_grant", 32'(g1 - s_g1), 32'd0);
        rsp_ready = '0;
        take(0);
        wait_grant();
        chk("t4_r1_next", 32'(req_ready), 32'd2);
        @(negedge clk);
        req_valid = '0;
        wait_rsp(1);
        take(1);

        hang = 1'b1;
        s_w = waits;
        req_valid = 2'b01;
        wait_grant();
        @(negedge clk);
        req_valid = '0;
        wait_rsp(0);
        chk("t5_nan", rsp_result, QNAN);
        chk("t5_flags", 32'(rsp_flags), 32'h10);
        chk("t5_wait_cycles", 32'(waits - s_w), 32'd8);
        take(0);
        hang = 1'b0;
        repeat (LAT + 2) @(negedge clk);

        hang = 1'b1;
        req_valid = 2'b11;
        wait_grant();
        chk("t6_grant_r1", 32'(req_ready), 32'd2);
        for (int k = 0; k < 10 && !alu_ready_in; k++) @(negedge clk);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("t6_rst_req_ready", 32'(req_ready), 32'd0);
        chk("t6_rst_ready_in", 32'(alu_ready_in), 32'd0);
        chk("t6_rst_op_a", alu_op_a, 32'd0);
        chk("t6_rst_result", rsp_result, 32'd0);
        s_v1 = v1;
        @(negedge clk);
        hang = 1'b0;
        rst_n = 1'b1;
        wait_grant();
        chk("t6_first_r0", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = '0;
        wait_rsp(0);
        chk("t6_result", rsp_result, 32'h41B8_0000);
        chk("t6_no_r1_rsp", 32'(v1 - s_v1), 32'd0);
        take(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
